pc_redirect_ctrl: RTL and testbench
===================================

Name: pc_redirect_ctrl

Overview:
- Sequencing controller for the fetch-stage PC register.
- Every cycle it selects the next PC from these sources: sequential, branch, jump, exception vector, or EPC on eret.
- It drives the PC write enable and generates the pipeline flushes.
- Any redirect that arrives while fetch is frozen is latched and applied as soon as fetch resumes. It sits between the hazard unit, the ID branch/jump logic, CP0 (M stage) and the PC register.

Parameters:
- RESET_PC, 32'h0000_3000, boot address and value of npc during reset/BOOT.
- EXC_VECTOR, 32'h0000_4180, exception/interrupt entry address.
- ADDR_W, 32, PC width.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- pc_cur  in  ADDR_W  current PC register value.
- stall_F  in  1  hazard-unit freeze of PC/IF.
- imem_busy  in  1  instruction memory cannot accept a new fetch address.
- br_taken_D  in  1  branch in ID resolved taken.
- br_target_D  in  ADDR_W  branch target.
- jmp_D  in  1  j/jal/jr in ID.
- jmp_target_D  in  ADDR_W  jump target.
- exc_M  in  1  exception/interrupt taken in M.
- eret_M  in  1  eret in M.
- epc  in  ADDR_W  CP0 EPC value.
- npc  out  ADDR_W  next PC to the PC register.
- pc_en  out  1  PC register load enable.
- if_flush  out  1  squash IF/ID register.
- dx_flush  out  1  squash ID/EX and EX/MEM registers (exception/eret only).
- redirect_pending  out  1  a latched redirect is waiting.

Behaviour:
- Registered state: fsm state (BOOT, RUN, HOLD, SETTLE), pend_v, pend_tgt, pend_cls (0 = branch/jump, 1 = exc/eret). All other outputs are combinational from the registered state and the current inputs.
- Reset: while rst=1, npc=RESET_PC, pc_en=0, if_flush=0, dx_flush=0, redirect_pending=0. At the next edge: state=BOOT, pend_v=0.
- Reset mid-operation discards any pending redirect.
- Source priority: exc_M > eret_M > jmp_D > br_taken_D > pending > pc_cur+4.
  - pc_cur+4 is modulo 2^ADDR_W; 32'hFFFF_FFFC wraps to 0.
  - Targets pass through unmodified; alignment checks happen elsewhere.
- "blocked" = imem_busy, or stall_F with no exc_M/eret_M in the same cycle.
  - exc_M/eret_M override stall_F but never imem_busy.
- BOOT:
  - npc=RESET_PC, pc_en=0.
  - Moves to RUN on the first cycle with imem_busy=0.
- RUN, not blocked:
  - npc = highest-priority source, pc_en=1.
  - if_flush=1 for exc, eret, jump, taken branch, or applied pending.
  - dx_flush=1 for exc/eret only.
  - exc/eret -> SETTLE; otherwise stay in RUN.
  - Applying a pending entry clears pend_v. A live exc/eret in the same cycle supersedes and clears it.
- RUN, blocked:
  - pc_en=0, flushes=0.
  - If any redirect is live, latch it: pend_v=1, tgt = its target, cls = its class.
  - A redirect with pend_cls=1 is overwritten only by another exc/eret.
  - Go to HOLD if pend_v is set after the update; else stay in RUN.
- HOLD:
  - pc_en=0 while blocked. New exc/eret overwrites the pending entry; branch/jump never overwrites cls=1.
  - When unblocked: apply the live exc/eret if present, else the pending entry. Set pc_en=1 and if_flush=1; set dx_flush=1 only for a live exc/eret. Clear pending.
  - Next state: SETTLE if the applied redirect was cls=1, else RUN.
- SETTLE (exactly 1 cycle):
  - exc_M/eret_M are ignored, because the M-stage instruction is already squashed.
  - Branch/jump/sequential behave as in RUN.
  - Next state: RUN, or HOLD if a redirect was latched.
- Latency: a live redirect reaches npc in the same cycle, so PC is updated at the next edge. A pending redirect is applied in the first unblocked cycle.
- Simultaneous exc_M and eret_M: exc wins.
- Simultaneous jmp_D and br_taken_D: jump wins.
- redirect_pending = pend_v.

Decomposition:
- Shared package cpu_pkg holds:
  - RESET_PC and EXC_VECTOR constants.
  - The fsm state enum.
  - The redirect-class encoding.
- One natural sub-module: redirect_mux, the combinational priority select that outputs target, class and valid. The FSM and pending register stay in the top.

Test Plan:
- Boot: rst=1 for 2 cycles, then imem_busy=1 for 3 cycles -> npc=0x3000 and pc_en=0 throughout. On release, pc_en=1 and npc=pc_cur+4=0x3004 (pc_cur=0x3000).
- Taken branch: pc_cur=0x3010, br_taken_D=1, br_target_D=0x3040 -> npc=0x3040, pc_en=1, if_flush=1, dx_flush=0.
- Stalled jump: stall_F=1 while jmp_D=1 with target 0x3100, then 2 more stall cycles -> pc_en=0 and redirect_pending=1. On stall release: npc=0x3100, if_flush=1, pending cleared.
- Exception during stall with pending branch: pending branch 0x3040 is latched, then exc_M=1 with stall_F=1 -> npc=0x4180, pc_en=1, if_flush=1, dx_flush=1, pending cleared. A repeated exc_M next cycle (SETTLE) is ignored and npc=pc_cur+4.
- eret under imem_busy: eret_M=1, epc=0x3208, imem_busy=1 -> latched as cls=1. A branch arriving meanwhile does not overwrite it. On release: npc=0x3208, dx_flush=1.
- Wrap and priority: pc_cur=0xFFFF_FFFC with no redirect -> npc=0. exc_M and eret_M together -> npc=0x4180.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the fetch-stage PC sequencing logic:
// boot/exception addresses, controller states and redirect classes.
package cpu_pkg;

  localparam logic [31:0] RESET_PC   = 32'h0000_3000;
  localparam logic [31:0] EXC_VECTOR = 32'h0000_4180;

  // Controller states. SETTLE lasts one cycle after an exc/eret has been
  // applied, while the squashed M-stage instruction may still be signalling.
  typedef enum logic [1:0] {
    ST_BOOT   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HOLD   = 2'd2,
    ST_SETTLE = 2'd3
  } pc_state_e;

  // Redirect class. An exc/eret redirect must never be displaced by a
  // younger branch/jump that sits in its shadow.
  typedef enum logic {
    CLS_BJ  = 1'b0,
    CLS_EXC = 1'b1
  } redir_cls_e;

endpackage

// File: rtl/redirect_mux.sv
// Priority select of the next-PC source:
// exc > eret > jump > taken branch > pending > pc_cur+4.
// The live outputs describe the winning live redirect only; sel_tgt also
// folds in the pending entry and the sequential address.
module redirect_mux
  import cpu_pkg::*;
#(
  parameter int unsigned       ADDR_W     = 32,
  parameter logic [ADDR_W-1:0] EXC_VECTOR = ADDR_W'(cpu_pkg::EXC_VECTOR)
) (
  input  logic              mask_m,
  input  logic              exc_M,
  input  logic              eret_M,
  input  logic [ADDR_W-1:0] epc,
  input  logic              jmp_D,
  input  logic [ADDR_W-1:0] jmp_target_D,
  input  logic              br_taken_D,
  input  logic [ADDR_W-1:0] br_target_D,
  input  logic [ADDR_W-1:0] pc_cur,
  input  logic              pend_v,
  input  logic [ADDR_W-1:0] pend_tgt,
  output logic              live_v,
  output logic [ADDR_W-1:0] live_tgt,
  output logic              live_cls,
  output logic [ADDR_W-1:0] sel_tgt
);

  localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(32'd4);

  logic [ADDR_W-1:0] seq_pc_s;
  logic              m_ok_s;

  // Sequential address wraps naturally modulo 2^ADDR_W.
  assign seq_pc_s = pc_cur + PC_STEP;
  assign m_ok_s   = ~mask_m;

  // Pick the highest-priority live redirect and its class.
  always_comb begin
    live_v   = 1'b1;
    live_tgt = seq_pc_s;
    live_cls = CLS_BJ;
    if (exc_M && m_ok_s) begin
      live_tgt = EXC_VECTOR;
      live_cls = CLS_EXC;
    end else if (eret_M && m_ok_s) begin
      live_tgt = epc;
      live_cls = CLS_EXC;
    end else if (jmp_D) begin
      live_tgt = jmp_target_D;
    end else if (br_taken_D) begin
      live_tgt = br_target_D;
    end else begin
      live_v   = 1'b0;
    end
  end

  assign sel_tgt = live_v ? live_tgt : (pend_v ? pend_tgt : seq_pc_s);

endmodule

// File: rtl/pc_redirect_ctrl.sv
// Fetch-stage PC sequencing controller. Chooses the next PC, drives the PC
// load enable and pipeline flushes, and parks a redirect that arrives while
// fetch is frozen until fetch can accept it.
module pc_redirect_ctrl
  import cpu_pkg::*;
#(
  parameter int unsigned       ADDR_W     = 32,
  parameter logic [ADDR_W-1:0] RESET_PC   = ADDR_W'(cpu_pkg::RESET_PC),
  parameter logic [ADDR_W-1:0] EXC_VECTOR = ADDR_W'(cpu_pkg::EXC_VECTOR)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc_cur,
  input  logic              stall_F,
  input  logic              imem_busy,
  input  logic              br_taken_D,
  input  logic [ADDR_W-1:0] br_target_D,
  input  logic              jmp_D,
  input  logic [ADDR_W-1:0] jmp_target_D,
  input  logic              exc_M,
  input  logic              eret_M,
  input  logic [ADDR_W-1:0] epc,
  output logic [ADDR_W-1:0] npc,
  output logic              pc_en,
  output logic              if_flush,
  output logic              dx_flush,
  output logic              redirect_pending
);

  pc_state_e         state_r;
  logic              pend_v_r;
  logic [ADDR_W-1:0] pend_tgt_r;
  logic              pend_cls_r;

  logic              mask_m_s;
  logic              live_v_s;
  logic [ADDR_W-1:0] live_tgt_s;
  logic              live_cls_s;
  logic [ADDR_W-1:0] sel_tgt_s;
  logic              m_live_s;
  logic              blocked_s;
  logic              latch_s;
  logic              hold_cls_s;

  // In SETTLE the M-stage instruction is already squashed, so its
  // exc/eret request is ignored.
  assign mask_m_s = (state_r == ST_SETTLE);

  redirect_mux #(
    .ADDR_W     (ADDR_W),
    .EXC_VECTOR (EXC_VECTOR)
  ) u_mux (
    .mask_m       (mask_m_s),
    .exc_M        (exc_M),
    .eret_M       (eret_M),
    .epc          (epc),
    .jmp_D        (jmp_D),
    .jmp_target_D (jmp_target_D),
    .br_taken_D   (br_taken_D),
    .br_target_D  (br_target_D),
    .pc_cur       (pc_cur),
    .pend_v       (pend_v_r),
    .pend_tgt     (pend_tgt_r),
    .live_v       (live_v_s),
    .live_tgt     (live_tgt_s),
    .live_cls     (live_cls_s),
    .sel_tgt      (sel_tgt_s)
  );

  // exc/eret beat a hazard stall but can never beat a busy imem.
  assign m_live_s   = live_v_s & (live_cls_s == CLS_EXC);
  assign blocked_s  = imem_busy | (stall_F & ~m_live_s);
  // An exc/eret entry can only be replaced by another exc/eret.
  assign latch_s    = live_v_s & (~pend_v_r | (pend_cls_r == CLS_BJ) | (live_cls_s == CLS_EXC));
  assign hold_cls_s = m_live_s ? CLS_EXC : pend_cls_r;

  // Next-PC, load enable and flush generation from state and live inputs.
  always_comb begin
    npc      = sel_tgt_s;
    pc_en    = 1'b0;
    if_flush = 1'b0;
    dx_flush = 1'b0;
    if (rst) begin
      npc = RESET_PC;
    end else begin
      case (state_r)
        ST_BOOT: begin
          npc = RESET_PC;
        end
        ST_RUN, ST_SETTLE: begin
          if (!blocked_s) begin
            pc_en    = 1'b1;
            if_flush = live_v_s | pend_v_r;
            dx_flush = m_live_s;
          end else begin
            pc_en    = 1'b0;
          end
        end
        ST_HOLD: begin
          if (!blocked_s) begin
            npc      = m_live_s ? live_tgt_s : pend_tgt_r;
            pc_en    = 1'b1;
            if_flush = 1'b1;
            dx_flush = m_live_s;
          end else begin
            npc      = pend_tgt_r;
          end
        end
        default: begin
          npc = RESET_PC;
        end
      endcase
    end
  end

  assign redirect_pending = pend_v_r & ~rst;

  // Controller FSM and pending-redirect register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_BOOT;
      pend_v_r   <= 1'b0;
      pend_tgt_r <= '0;
      pend_cls_r <= CLS_BJ;
    end else begin
      case (state_r)
        ST_BOOT: begin
          state_r <= imem_busy ? ST_BOOT : ST_RUN;
        end
        ST_RUN, ST_SETTLE: begin
          if (!blocked_s) begin
            pend_v_r <= 1'b0;
            state_r  <= m_live_s ? ST_SETTLE : ST_RUN;
          end else if (latch_s) begin
            pend_v_r   <= 1'b1;
            pend_tgt_r <= live_tgt_s;
            pend_cls_r <= live_cls_s;
            state_r    <= ST_HOLD;
          end else begin
            state_r    <= pend_v_r ? ST_HOLD : ST_RUN;
          end
        end
        ST_HOLD: begin
          if (!blocked_s) begin
            pend_v_r <= 1'b0;
            state_r  <= (hold_cls_s == CLS_EXC) ? ST_SETTLE : ST_RUN;
          end else if (latch_s) begin
            pend_v_r   <= 1'b1;
            pend_tgt_r <= live_tgt_s;
            pend_cls_r <= live_cls_s;
          end else begin
            state_r    <= ST_HOLD;
          end
        end
        default: begin
          state_r  <= ST_BOOT;
          pend_v_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Self-checking bench for pc_redirect_ctrl: directed scenarios followed by
// random traffic, all compared against a behavioural model that tracks
// "booted", "settle window" and a one-deep queue of parked redirects.
module tb_pc_redirect_ctrl;

  logic        clk;
  logic        rst;
  logic [31:0] pc_cur;
  logic        stall_F;
  logic        imem_busy;
  logic        br_taken_D;
  logic [31:0] br_target_D;
  logic        jmp_D;
  logic [31:0] jmp_target_D;
  logic        exc_M;
  logic        eret_M;
  logic [31:0] epc;
  logic [31:0] npc;
  logic        pc_en;
  logic        if_flush;
  logic        dx_flush;
  logic        redirect_pending;

  int total = 0;
  int bad   = 0;

  localparam logic [31:0] BOOT_A = 32'h0000_3000;
  localparam logic [31:0] EXC_A  = 32'h0000_4180;

  pc_redirect_ctrl dut (
    .clk              (clk),
    .rst              (rst),
    .pc_cur           (pc_cur),
    .stall_F          (stall_F),
    .imem_busy        (imem_busy),
    .br_taken_D       (br_taken_D),
    .br_target_D      (br_target_D),
    .jmp_D            (jmp_D),
    .jmp_target_D     (jmp_target_D),
    .exc_M            (exc_M),
    .eret_M           (eret_M),
    .epc              (epc),
    .npc              (npc),
    .pc_en            (pc_en),
    .if_flush         (if_flush),
    .dx_flush         (dx_flush),
    .redirect_pending (redirect_pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model state.
  typedef struct {
    logic [31:0] tgt;
    bit          cls;
  } pend_t;

  pend_t       pq[$];
  bit          m_booted = 1'b0;
  bit          m_settle = 1'b0;
  bit          n_booted;
  bit          n_settle;
  bit          n_clear;
  bit          n_latch;
  logic [31:0] n_tgt;
  bit          n_cls;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Sample at the falling edge, compare with the model, prepare its update.
  task automatic eval();
    logic [31:0] e_npc;
    logic [31:0] ltgt;
    bit e_en, e_if, e_dx, e_pend, ex, er, lv, lcls, blocked, chk_npc;
    @(negedge clk);
    e_npc = BOOT_A; e_en = 1'b0; e_if = 1'b0; e_dx = 1'b0;
    e_pend = (pq.size() != 0);
    chk_npc = 1'b1;
    n_booted = m_booted; n_settle = 1'b0; n_clear = 1'b0; n_latch = 1'b0;
    n_tgt = 32'h0; n_cls = 1'b0;
    if (rst) begin
      e_pend = 1'b0; n_booted = 1'b0; n_clear = 1'b1;
    end else if (!m_booted) begin
      n_booted = !imem_busy;
    end else begin
      ex = exc_M && !m_settle;
      er = eret_M && !m_settle;
      lv = 1'b1; lcls = 1'b0;
      if (ex) begin ltgt = EXC_A; lcls = 1'b1; end
      else if (er) begin ltgt = epc; lcls = 1'b1; end
      else if (jmp_D) ltgt = jmp_target_D;
      else if (br_taken_D) ltgt = br_target_D;
      else begin lv = 1'b0; ltgt = pc_cur + 32'd4; end
      blocked = imem_busy || (stall_F && !(ex || er));
      if (!blocked) begin
        e_en = 1'b1; e_dx = ex || er; n_clear = 1'b1;
        if (pq.size() != 0) begin
          e_if = 1'b1;
          e_npc = (ex || er) ? ltgt : pq[0].tgt;
          n_settle = (ex || er) ? 1'b1 : pq[0].cls;
        end else begin
          e_if = lv; e_npc = ltgt; n_settle = ex || er;
        end
      end else begin
        chk_npc = 1'b0;
        if (lv && (pq.size() == 0 || !pq[0].cls || lcls)) begin
          n_latch = 1'b1; n_tgt = ltgt; n_cls = lcls;
        end
      end
    end
    check_eq("pc_en",    {31'b0, pc_en},            {31'b0, e_en});
    check_eq("if_flush", {31'b0, if_flush},         {31'b0, e_if});
    check_eq("dx_flush", {31'b0, dx_flush},         {31'b0, e_dx});
    check_eq("pending",  {31'b0, redirect_pending}, {31'b0, e_pend});
    if (chk_npc) check_eq("npc", npc, e_npc);
  endtask

  // Advance the model and the clock; inputs may change 1 ns after the edge.
  task automatic adv();
    pend_t p;
    m_booted = n_booted;
    m_settle = n_settle;
    if (n_clear) pq.delete();
    if (n_latch) begin
      pq.delete();
      p.tgt = n_tgt; p.cls = n_cls;
      pq.push_back(p);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    stall_F = 1'b0; imem_busy = 1'b0; br_taken_D = 1'b0; jmp_D = 1'b0;
    exc_M = 1'b0; eret_M = 1'b0;
  endtask

  initial begin
    rst = 1'b1; pc_cur = 32'h0000_3000; br_target_D = 32'h0; jmp_target_D = 32'h0;
    epc = 32'h0; idle();

    // Boot: reset two cycles, then imem busy three cycles.
    for (int i = 0; i < 2; i++) begin
      eval(); check_eq("rst_npc", npc, BOOT_A); adv();
    end
    rst = 1'b0; imem_busy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      eval(); check_eq("boot_npc", npc, BOOT_A); check_eq("boot_en", {31'b0, pc_en}, 32'd0); adv();
    end
    imem_busy = 1'b0;
    eval(); adv();
    eval(); check_eq("boot_seq", npc, 32'h0000_3004); check_eq("boot_en1", {31'b0, pc_en}, 32'd1); adv();

    // Taken branch.
    pc_cur = 32'h0000_3010; br_taken_D = 1'b1; br_target_D = 32'h0000_3040;
    eval(); check_eq("br_npc", npc, 32'h0000_3040); check_eq("br_dx", {31'b0, dx_flush}, 32'd0); adv();
    idle();

    // Stalled jump, released after two more stall cycles.
    stall_F = 1'b1; jmp_D = 1'b1; jmp_target_D = 32'h0000_3100;
    for (int i = 0; i < 3; i++) begin eval(); adv(); end
    check_eq("jmp_pend", {31'b0, redirect_pending}, 32'd1);
    idle();
    eval(); check_eq("jmp_npc", npc, 32'h0000_3100); check_eq("jmp_if", {31'b0, if_flush}, 32'd1); adv();
    eval(); check_eq("jmp_clr", {31'b0, redirect_pending}, 32'd0); adv();

    // Exception during a stall while a branch is parked.
    stall_F = 1'b1; br_taken_D = 1'b1; br_target_D = 32'h0000_3040;
    eval(); adv();
    br_taken_D = 1'b0; exc_M = 1'b1;
    eval(); check_eq("exc_npc", npc, EXC_A); check_eq("exc_dx", {31'b0, dx_flush}, 32'd1); adv();
    stall_F = 1'b0; pc_cur = 32'h0000_3050;
    eval(); check_eq("settle_npc", npc, 32'h0000_3054); check_eq("settle_dx", {31'b0, dx_flush}, 32'd0); adv();
    idle();
    eval(); adv();

    // eret parked under imem_busy, a branch must not displace it.
    eret_M = 1'b1; epc = 32'h0000_3208; imem_busy = 1'b1;
    eval(); adv();
    br_taken_D = 1'b1; br_target_D = 32'h0000_3300;
    eval(); adv();
    br_taken_D = 1'b0; imem_busy = 1'b0;
    eval(); check_eq("eret_npc", npc, 32'h0000_3208); check_eq("eret_dx", {31'b0, dx_flush}, 32'd1); adv();
    idle();

    // Sequential wrap, then simultaneous exc and eret.
    pc_cur = 32'hFFFF_FFFC;
    eval(); check_eq("wrap_npc", npc, 32'h0000_0000); adv();
    exc_M = 1'b1; eret_M = 1'b1; epc = 32'h0000_3500;
    eval(); check_eq("exc_eret", npc, EXC_A); adv();
    idle();

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      rst          = ($urandom_range(0, 99) == 0);
      imem_busy    = ($urandom_range(0, 99) < 20);
      stall_F      = ($urandom_range(0, 99) < 25);
      exc_M        = ($urandom_range(0, 99) < 8);
      eret_M       = ($urandom_range(0, 99) < 8);
      jmp_D        = ($urandom_range(0, 99) < 15);
      br_taken_D   = ($urandom_range(0, 99) < 15);
      pc_cur       = ($urandom_range(0, 19) == 0) ? 32'hFFFF_FFFC : ($urandom() & 32'hFFFF_FFFC);
      br_target_D  = $urandom();
      jmp_target_D = $urandom();
      epc          = $urandom();
      eval(); adv();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
